// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC frame extractor.
// Holds FSM encodings, sample widths and saturation bounds.
package adc_frame_pkg;

    localparam int CYCLE_SAMPLE_NUM = 16;
    localparam int IN_SAMPLE_WIDTH  = 16;
    localparam int OUT_SAMPLE_WIDTH = 8;
    localparam int DATA_WIDTH       = CYCLE_SAMPLE_NUM * IN_SAMPLE_WIDTH;
    localparam int OUT_WIDTH        = CYCLE_SAMPLE_NUM * OUT_SAMPLE_WIDTH;
    localparam int DIFF_WIDTH       = IN_SAMPLE_WIDTH + 1;
    localparam int SHIFT_WIDTH      = 4;
    localparam int CNT_WIDTH        = 16;

    localparam logic signed [DIFF_WIDTH-1:0] SAT_MAX = 17'sd127;
    localparam logic signed [DIFF_WIDTH-1:0] SAT_MIN = -17'sd128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_PAYLOAD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/adc_frame_extract_sample_scale_sat.sv
// Per-sample pipeline: offset removal, then arithmetic shift
// and saturation to a signed 8-bit value.
import adc_frame_pkg::*;

module sample_scale_sat (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s1_en_i,
    input  logic                        s2_en_i,
    input  logic [IN_SAMPLE_WIDTH-1:0]  sample_i,
    input  logic [IN_SAMPLE_WIDTH-1:0]  offset_i,
    input  logic [SHIFT_WIDTH-1:0]      shift_i,
    output logic [OUT_SAMPLE_WIDTH-1:0] sample_o
);

    logic signed [DIFF_WIDTH-1:0] diff_d, diff_q;
    logic signed [DIFF_WIDTH-1:0] shifted;
    logic [OUT_SAMPLE_WIDTH-1:0]  sat_d, sat_q;

    always_comb begin
        diff_d  = {1'b0, sample_i} - {1'b0, offset_i};
        shifted = diff_q >>> shift_i;
        if (shifted > SAT_MAX) begin
            sat_d = SAT_MAX[OUT_SAMPLE_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_d = SAT_MIN[OUT_SAMPLE_WIDTH-1:0];
        end else begin
            sat_d = shifted[OUT_SAMPLE_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q <= '0;
            sat_q  <= '0;
        end else begin
            if (s1_en_i) diff_q <= diff_d;
            if (s2_en_i) sat_q  <= sat_d;
        end
    end

    assign sample_o = sat_q;

endmodule

// File: rtl/adc_frame_extract.sv
// Captures a payload window after a skip count, converts samples
// to signed 8-bit and streams them out with tlast and statistics.
import adc_frame_pkg::*;

module adc_frame_extract (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   state_changed,
    input  logic [DATA_WIDTH-1:0]  s_tdata,
    input  logic                   s_tvalid,
    input  logic [CNT_WIDTH-1:0]   skip_cycle_length,
    input  logic [CNT_WIDTH-1:0]   payload_cycle_length,
    input  logic [15:0]            adc_offset,
    input  logic [SHIFT_WIDTH-1:0] scale_shift,
    output logic [OUT_WIDTH-1:0]   m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [CNT_WIDTH-1:0]   frame_count,
    output logic [CNT_WIDTH-1:0]   drop_count,
    output logic                   frame_error,
    output logic                   busy
);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_nxt;
    logic [CNT_WIDTH-1:0]   skip_q, payload_q;
    logic [15:0]            offset_q, offset_sel;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic                   s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic                   out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic                   err_q, err_d;
    logic                   cfg_load, cap, cap_last, frame_inc, gap;
    logic                   hold, drop, s2_en;
    logic [OUT_SAMPLE_WIDTH-1:0] smp [CYCLE_SAMPLE_NUM];

    assign cnt_nxt = cnt_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cfg_load  = 1'b0;
        cap       = 1'b0;
        cap_last  = 1'b0;
        frame_inc = 1'b0;
        gap       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (s_tvalid && payload_cycle_length != '0) begin
                    cfg_load = 1'b1;
                    if (skip_cycle_length == '0) begin
                        cap       = 1'b1;
                        cnt_d     = 16'd1;
                        cap_last  = (payload_cycle_length == 16'd1);
                        frame_inc = cap_last;
                        state_d   = cap_last ? ST_DONE : ST_PAYLOAD;
                    end else if (skip_cycle_length == 16'd1) begin
                        cnt_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        cnt_d   = 16'd1;
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                if (!s_tvalid) begin
                    gap     = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_nxt == skip_q) begin
                    cnt_d   = '0;
                    state_d = ST_PAYLOAD;
                end else begin
                    cnt_d = cnt_nxt;
                end
            end
            ST_PAYLOAD: begin
                if (!s_tvalid) begin
                    gap     = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cap       = 1'b1;
                    cnt_d     = cnt_nxt;
                    cap_last  = (cnt_nxt == payload_q);
                    frame_inc = cap_last;
                    if (cap_last) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
        endcase
        // Re-arm overrides everything the FSM decided this cycle
        if (state_changed) begin
            state_d   = ST_IDLE;
            cfg_load  = 1'b0;
            cap       = 1'b0;
            cap_last  = 1'b0;
            frame_inc = 1'b0;
            gap       = 1'b0;
        end
    end

    always_comb begin
        hold       = out_vld_q && !m_axis_tready;
        drop       = hold && s1_vld_q && !state_changed;
        s2_en      = s1_vld_q && !hold;
        s1_vld_d   = cap;
        s1_last_d  = cap_last;
        out_vld_d  = hold ? out_vld_q  : s1_vld_q;
        out_last_d = hold ? out_last_q : s1_last_q;
        frame_cnt_d = frame_inc ? frame_cnt_q + 16'd1 : frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        err_d = err_q || gap || drop;
        if (state_changed) begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
            drop_cnt_d = '0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            skip_q      <= '0;
            payload_q   <= '0;
            offset_q    <= '0;
            shift_q     <= '0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            out_vld_q   <= out_vld_d;
            out_last_q  <= out_last_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            err_q       <= err_d;
            if (cfg_load) begin
                skip_q    <= skip_cycle_length;
                payload_q <= payload_cycle_length;
                offset_q  <= adc_offset;
                shift_q   <= scale_shift;
            end
        end
    end

    // The first payload word can be captured on the same edge the
    // configuration is latched, so stage 1 uses the live offset in IDLE.
    assign offset_sel = (state_q == ST_IDLE) ? adc_offset : offset_q;

    for (genvar i = 0; i < CYCLE_SAMPLE_NUM; i++) begin : g_lane
        sample_scale_sat u_sss (
            .clk      (clk),
            .rst      (rst),
            .s1_en_i  (cap),
            .s2_en_i  (s2_en),
            .sample_i (s_tdata[i*IN_SAMPLE_WIDTH +: IN_SAMPLE_WIDTH]),
            .offset_i (offset_sel),
            .shift_i  (shift_q),
            .sample_o (smp[i])
        );
    end

    always_comb begin
        m_axis_tdata = '0;
        for (int i = 0; i < CYCLE_SAMPLE_NUM; i++) begin
            m_axis_tdata[i*OUT_SAMPLE_WIDTH +: OUT_SAMPLE_WIDTH] = smp[i];
        end
    end

    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tlast  = out_last_q;
    assign frame_count   = frame_cnt_q;
    assign drop_count    = drop_cnt_q;
    assign frame_error   = err_q;
    assign busy          = (state_q == ST_SKIP) || (state_q == ST_PAYLOAD);

endmodule
